param_data_memory: RTL
======================

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter ADDR_W, default 12: address width; depth = 2**ADDR_W words.
REQ-003 Parameter CLEAR_ON_RESET, default 1: when 1, memory is zero-filled after reset; when 0, the block enters READY directly.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_be  input  DATA_W/8  byte enables for writes; bit i covers bits 8i+7:8i.
REQ-010 req_addr  input  ADDR_W  word address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  one-cycle pulse; rsp_rdata is valid.
REQ-013 rsp_rdata  output  DATA_W  read data.
REQ-014 clear_start  input  1  request a full zero-fill.
REQ-015 busy  output  1  clear sweep in progress.

Function
REQ-016 FSM states: CLEAR and READY; req_ready SHALL be 1 only in READY; busy SHALL be 1 only in CLEAR.
REQ-017 CLEAR: one word written to zero per cycle, address counter 0 to 2**ADDR_W-1; after the last address the FSM SHALL enter READY on the next edge; the sweep takes exactly 2**ADDR_W cycles.
REQ-018 READY with clear_start=1 and no accepted request: enter CLEAR with counter 0; clear_start with a simultaneous accepted request: the request completes first and CLEAR starts on the following cycle.
REQ-019 clear_start during CLEAR SHALL be ignored; the sweep does not restart.
REQ-020 Accept = req_valid & req_ready; requests without accept SHALL have no effect.
REQ-021 Accepted write: at that edge, each byte lane with req_be=1 updated from req_wdata; other lanes unchanged; no response generated.
REQ-022 Accepted write with req_be all zero SHALL leave memory unchanged.
REQ-023 Accepted read: rsp_valid=1 and rsp_rdata=mem[req_addr] on the cycle after accept (latency 1); back-to-back reads SHALL give one response per cycle.
REQ-024 Read accepted the cycle after a write to the same address SHALL return the written data.
REQ-025 rsp_rdata SHALL hold its last value while rsp_valid=0.
REQ-026 Address counter and req_addr index the full depth; no out-of-range condition exists.

Reset
REQ-027 On rst: rsp_valid=0, rsp_rdata=0, counter=0; state=CLEAR (busy=1, req_ready=0) if CLEAR_ON_RESET=1, else READY (busy=0, req_ready=1).
REQ-028 rst asserted mid-sweep SHALL abort it; the sweep restarts from address 0 after release when CLEAR_ON_RESET=1.
REQ-029 Memory array SHALL NOT be reset directly; contents are changed only by writes and clear sweeps.

Structure
REQ-030 Shared package holds the FSM state enum (CLEAR, READY) and default parameter constants.
REQ-031 Storage SHALL be a sub-module param_data_memory_ram: one synchronous port with byte-write enables and 1-cycle read, inferable as block RAM; the top holds the FSM, counter, and muxing.

Verification
REQ-032 Reset with CLEAR_ON_RESET=1, ADDR_W=4 -> busy=1 for 16 cycles, then req_ready=1; reads of all 16 addresses return 0x0000.
REQ-033 Write 0xABCD to addr 5 with be=11, then read addr 5 on the next cycle -> rsp_valid one cycle later, rsp_rdata=0xABCD.
REQ-034 Write 0x1234 to addr 3 with be=01 over existing 0xABCD -> read returns 0xAB34; write with be=00 -> read unchanged.
REQ-035 clear_start in READY with addr 7 holding 0x5555 -> busy for 2**ADDR_W cycles, req_ready=0, requests ignored; addr 7 reads 0x0000 afterwards.
REQ-036 rst pulse at sweep address 9 -> rsp_valid=0 immediately; after release the sweep restarts at 0 and lasts the full depth.

Source files
------------

// File: rtl/param_data_memory_pkg.sv
// Shared types and default sizing for the byte-writable data memory.
package param_data_memory_pkg;

  localparam int DEF_DATA_W         = 16;
  localparam int DEF_ADDR_W         = 12;
  localparam bit DEF_CLEAR_ON_RESET = 1'b1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/param_data_memory_ram.sv
// Single-port synchronous RAM with per-byte write enables and a 1-cycle read.
module param_data_memory_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_data_memory.sv
// Byte-writable data memory with a zero-fill sweep; the FSM owns the RAM port while clearing.
module param_data_memory
  import param_data_memory_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter bit CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic                clear_start,
  output logic                busy
);

  localparam int NB = DATA_W / 8;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, busy_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_hold_q, rsp_rdata_d;
  logic              accept;

  logic              ram_en, ram_we;
  logic [NB-1:0]     ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign accept = req_valid & (state_q == ST_READY);

  // A clear_start coinciding with an accepted request still lets that request
  // use the RAM port this cycle; the sweep begins on the next one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_READY;
      end
      ST_READY: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_comb begin
    rsp_valid_d = accept & ~req_we;
    rsp_rdata_d = rsp_valid_q ? ram_rdata : rsp_hold_q;
  end

  always_comb begin
    ram_en    = accept;
    ram_we    = req_we;
    ram_be    = req_be;
    ram_addr  = req_addr;
    ram_wdata = req_wdata;
    if (state_q == ST_CLEAR) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = cnt_q;
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt_q       <= '0;
      ready_q     <= ~CLEAR_ON_RESET;
      busy_q      <= CLEAR_ON_RESET;
      rsp_valid_q <= 1'b0;
      rsp_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= (state_d == ST_READY);
      busy_q      <= (state_d == ST_CLEAR);
      rsp_valid_q <= rsp_valid_d;
      rsp_hold_q  <= rsp_rdata_d;
    end
  end

  param_data_memory_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_d;

endmodule
